// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch with credit-limited imem requests, response FIFO and IF/ID register
//   clk/rst           : clock, synchronous active-high reset
//   stall             : decode not ready, IF/ID holds
//   pc_we/pc_data     : redirect from decode, squashes wrong-path work
//   imem_*            : req/gnt/rvalid instruction memory interface
//   pc_id/ir_id/valid_id : IF/ID pipeline register (pc_id = instruction address + 4)
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2,
  parameter logic [31:0] NOP_INSN   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        pc_we,
  input  logic [31:0] pc_data,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic        imem_gnt,
  input  logic [31:0] imem_rdata,
  input  logic        imem_rvalid,
  output logic [31:0] pc_id,
  output logic [31:0] ir_id,
  output logic        valid_id
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH = FIFO_DEPTH[CW:0];
  logic [31:0] fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d;
  logic [31:0] pc_id_q, pc_id_d, ir_id_q, ir_id_d;
  logic        valid_q, valid_d;
  logic [CW-1:0] out_q, out_d, disc_q, disc_d, cnt_q, cnt_d;
  logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [31:0] fifo_pc_q [FIFO_DEPTH];
  logic [31:0] fifo_ir_q [FIFO_DEPTH];
  logic fire, resp, keep, hold, pop, byp, push;
  // a request is only issued if its response is guaranteed a FIFO slot
  assign imem_req  = !rst && !pc_we && ({1'b0, out_q} + {1'b0, cnt_q} < DEPTH);
  assign imem_addr = {fetch_pc_q[31:2], 2'b00};
  assign fire = imem_req && imem_gnt;
  assign resp = imem_rvalid && out_q != '0;
  // responses owed to squashed requests, or arriving in a redirect cycle, are dropped
  assign keep = resp && disc_q == '0 && !pc_we;
  assign hold = stall && !pc_we;
  assign pop  = !stall && !pc_we && cnt_q != '0;
  assign byp  = keep && !stall && cnt_q == '0;
  assign push = keep && !byp;
  assign pc_id    = pc_id_q;
  assign ir_id    = ir_id_q;
  assign valid_id = valid_q;
  always_comb begin
    fetch_pc_d = pc_we ? pc_data : fire ? fetch_pc_q + 32'd4 : fetch_pc_q;
    resp_pc_d  = pc_we ? pc_data : keep ? resp_pc_q + 32'd4 : resp_pc_q;
    out_d      = out_q + CW'(fire) - CW'(resp);
    disc_d     = pc_we ? out_q - CW'(resp) : (resp && disc_q != '0) ? disc_q - CW'(1) : disc_q;
    cnt_d      = pc_we ? '0 : cnt_q + CW'(push) - CW'(pop);
    wp_d       = pc_we ? '0 : wp_q + PW'(push);
    rp_d       = pc_we ? '0 : rp_q + PW'(pop);
    pc_id_d    = pop ? fifo_pc_q[rp_q] + 32'd4 : byp ? resp_pc_q + 32'd4 : pc_id_q;
    ir_id_d    = hold ? ir_id_q : pop ? fifo_ir_q[rp_q] : byp ? imem_rdata : NOP_INSN;
    valid_d    = hold ? valid_q : pop || byp;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      out_q      <= '0;
      disc_q     <= '0;
      cnt_q      <= '0;
      wp_q       <= '0;
      rp_q       <= '0;
      pc_id_q    <= '0;
      ir_id_q    <= NOP_INSN;
      valid_q    <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      out_q      <= out_d;
      disc_q     <= disc_d;
      cnt_q      <= cnt_d;
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      pc_id_q    <= pc_id_d;
      ir_id_q    <= ir_id_d;
      valid_q    <= valid_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc_q[wp_q] <= resp_pc_q;
      fifo_ir_q[wp_q] <= imem_rdata;
    end
  end
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && cnt_q == DEPTH[CW-1:0]))
    else $error("fetch_stage: push into full instruction buffer");
  a_no_stray_rvalid: assert property (@(posedge clk) disable iff (rst)
    !(imem_rvalid && out_q == '0))
    else $error("fetch_stage: rvalid with no outstanding request");
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed self-checking bench for fetch_stage
module tb_fetch_stage;
  logic clk = 1'b0, rst = 1'b1, stall = 1'b0, pc_we = 1'b0, imem_gnt = 1'b1;
  logic [31:0] pc_data = '0;
  logic [31:0] imem_addr, imem_rdata, pc_id, ir_id;
  logic imem_req, imem_rvalid, valid_id;
  int tests = 0, fails = 0, lat = 1;
  logic v0 = 1'b0, v1 = 1'b0, v2 = 1'b0;
  logic [31:0] a0 = '0, a1 = '0, a2 = '0;
  fetch_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .pc_we(pc_we), .pc_data(pc_data),
    .imem_addr(imem_addr), .imem_req(imem_req), .imem_gnt(imem_gnt),
    .imem_rdata(imem_rdata), .imem_rvalid(imem_rvalid),
    .pc_id(pc_id), .ir_id(ir_id), .valid_id(valid_id)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    v0 <= imem_req && imem_gnt;
    a0 <= imem_addr;
    v1 <= v0;
    a1 <= a0;
    v2 <= v1;
    a2 <= a1;
  end
  assign imem_rvalid = (lat == 1) ? v0 : v2;
  assign imem_rdata  = (lat == 1) ? a0 : a2;

  task automatic do_reset(input int l);
    @(negedge clk);
    rst = 1'b1; stall = 1'b0; pc_we = 1'b0; pc_data = '0; imem_gnt = 1'b1; lat = l;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset(1);
    #1;
    tests++;
    if ({imem_req, valid_id, ir_id, pc_id} !== {1'b0, 1'b0, 32'h0, 32'h0}) begin
      fails++;
      $display("FAIL reset_values: got req=%b v=%b ir=%h pc=%h, want 0 0 0 0", imem_req, valid_id, ir_id, pc_id);
    end
    rst = 1'b0;
    #1;
    tests++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
      fails++;
      $display("FAIL reset_first_req: got req=%b addr=%h, want 1 00000000", imem_req, imem_addr);
    end
  endtask

  task automatic test_stream();
    @(negedge clk);
    tests++;
    if ({valid_id, imem_addr} !== {1'b0, 32'h4}) begin
      fails++;
      $display("FAIL stream_n1: got v=%b addr=%h, want 0 00000004", valid_id, imem_addr);
    end
    @(negedge clk);
    tests++;
    if ({valid_id, ir_id, pc_id, imem_addr} !== {1'b1, 32'h0, 32'h4, 32'h8}) begin
      fails++;
      $display("FAIL stream_n2: got v=%b ir=%h pc=%h addr=%h, want 1 0 4 8", valid_id, ir_id, pc_id, imem_addr);
    end
    for (int k = 3; k <= 7; k++) begin
      @(negedge clk);
      tests++;
      if ({valid_id, ir_id, pc_id} !== {1'b1, 32'(4 * (k - 2)), 32'(4 * (k - 1))}) begin
        fails++;
        $display("FAIL stream_k%0d: got v=%b ir=%h pc=%h, want 1 %h %h", k, valid_id, ir_id, pc_id, 32'(4 * (k - 2)), 32'(4 * (k - 1)));
      end
    end
  endtask

  task automatic test_stall();
    do_reset(1);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    stall = 1'b1;
    for (int i = 4; i <= 7; i++) begin
      @(negedge clk);
      tests++;
      if ({valid_id, ir_id, pc_id, imem_req} !== {1'b1, 32'h4, 32'h8, 1'b0}) begin
        fails++;
        $display("FAIL stall_hold_n%0d: got v=%b ir=%h pc=%h req=%b, want 1 4 8 0", i, valid_id, ir_id, pc_id, imem_req);
      end
    end
    stall = 1'b0;
    for (int i = 8; i <= 11; i++) begin
      @(negedge clk);
      tests++;
      if ({valid_id, ir_id, pc_id} !== {1'b1, 32'(4 * (i - 6)), 32'(4 * (i - 5))}) begin
        fails++;
        $display("FAIL stall_release_n%0d: got v=%b ir=%h pc=%h, want 1 %h %h", i, valid_id, ir_id, pc_id, 32'(4 * (i - 6)), 32'(4 * (i - 5)));
      end
    end
  endtask

  task automatic test_redirect();
    do_reset(1);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    pc_we = 1'b1; pc_data = 32'h100;
    #1;
    tests++;
    if (imem_req !== 1'b0) begin
      fails++;
      $display("FAIL redirect_noreq: got req=%b, want 0", imem_req);
    end
    @(negedge clk);
    tests++;
    if ({valid_id, ir_id} !== {1'b0, 32'h0}) begin
      fails++;
      $display("FAIL redirect_squash: got v=%b ir=%h, want 0 0", valid_id, ir_id);
    end
    pc_we = 1'b0;
    #1;
    tests++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h100}) begin
      fails++;
      $display("FAIL redirect_target_req: got req=%b addr=%h, want 1 00000100", imem_req, imem_addr);
    end
    @(negedge clk);
    tests++;
    if (valid_id !== 1'b0) begin
      fails++;
      $display("FAIL redirect_bubble: got v=%b, want 0", valid_id);
    end
    @(negedge clk);
    tests++;
    if ({valid_id, ir_id, pc_id} !== {1'b1, 32'h100, 32'h104}) begin
      fails++;
      $display("FAIL redirect_target: got v=%b ir=%h pc=%h, want 1 100 104", valid_id, ir_id, pc_id);
    end
    @(negedge clk);
    tests++;
    if ({valid_id, ir_id, pc_id} !== {1'b1, 32'h104, 32'h108}) begin
      fails++;
      $display("FAIL redirect_next: got v=%b ir=%h pc=%h, want 1 104 108", valid_id, ir_id, pc_id);
    end
  endtask

  task automatic test_gnt_hold();
    do_reset(1);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    imem_gnt = 1'b0;
    for (int i = 3; i <= 5; i++) begin
      @(negedge clk);
      tests++;
      if ({imem_req, imem_addr} !== {1'b1, 32'h8}) begin
        fails++;
        $display("FAIL gnt_hold_n%0d: got req=%b addr=%h, want 1 00000008", i, imem_req, imem_addr);
      end
    end
    imem_gnt = 1'b1;
    @(negedge clk);
    tests++;
    if (imem_addr !== 32'hC) begin
      fails++;
      $display("FAIL gnt_advance: got addr=%h, want 0000000c", imem_addr);
    end
    @(negedge clk);
    tests++;
    if ({valid_id, ir_id, pc_id} !== {1'b1, 32'h8, 32'hC}) begin
      fails++;
      $display("FAIL gnt_data: got v=%b ir=%h pc=%h, want 1 8 c", valid_id, ir_id, pc_id);
    end
  endtask

  task automatic test_latency3();
    logic        exp_v   [13] = '{0, 0, 0, 1, 1, 0, 0, 1, 1, 0, 0, 1, 1};
    logic        exp_req [13] = '{1, 0, 0, 1, 1, 0, 0, 1, 1, 0, 0, 1, 1};
    logic [31:0] exp_ir  [13] = '{0, 0, 0, 0, 4, 0, 0, 8, 32'hC, 0, 0, 32'h10, 32'h14};
    do_reset(3);
    rst = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      tests++;
      if ({valid_id, ir_id, imem_req} !== {exp_v[k-1], exp_ir[k-1], exp_req[k-1]}) begin
        fails++;
        $display("FAIL lat3_n%0d: got v=%b ir=%h req=%b, want %b %h %b", k, valid_id, ir_id, imem_req, exp_v[k-1], exp_ir[k-1], exp_req[k-1]);
      end
    end
  endtask

  task automatic test_redirect_discard();
    do_reset(3);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    pc_we = 1'b1; pc_data = 32'h200;
    @(negedge clk);
    pc_we = 1'b0;
    #1;
    tests++;
    if ({valid_id, imem_req} !== {1'b0, 1'b0}) begin
      fails++;
      $display("FAIL discard_n3: got v=%b req=%b, want 0 0", valid_id, imem_req);
    end
    @(negedge clk);
    tests++;
    if ({valid_id, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h200}) begin
      fails++;
      $display("FAIL discard_n4: got v=%b req=%b addr=%h, want 0 1 00000200", valid_id, imem_req, imem_addr);
    end
    for (int i = 5; i <= 7; i++) begin
      @(negedge clk);
      tests++;
      if (valid_id !== 1'b0) begin
        fails++;
        $display("FAIL discard_bubble_n%0d: got v=%b ir=%h, want 0", i, valid_id, ir_id);
      end
    end
    for (int i = 8; i <= 9; i++) begin
      @(negedge clk);
      tests++;
      if ({valid_id, ir_id, pc_id} !== {1'b1, 32'h200 + 32'(4 * (i - 8)), 32'h204 + 32'(4 * (i - 8))}) begin
        fails++;
        $display("FAIL discard_target_n%0d: got v=%b ir=%h pc=%h", i, valid_id, ir_id, pc_id);
      end
    end
  endtask

  task automatic test_reset_midstream();
    do_reset(3);
    rst = 1'b0;
    repeat (9) @(negedge clk);
    tests++;
    if ({valid_id, ir_id, pc_id} !== {1'b1, 32'hC, 32'h10}) begin
      fails++;
      $display("FAIL mid_pre: got v=%b ir=%h pc=%h, want 1 c 10", valid_id, ir_id, pc_id);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    tests++;
    if ({imem_req, pc_id} !== {1'b0, 32'h10}) begin
      fails++;
      $display("FAIL mid_rst_req: got req=%b pc=%h, want 0 10", imem_req, pc_id);
    end
    for (int i = 11; i <= 14; i++) begin
      @(negedge clk);
      tests++;
      if ({imem_req, valid_id, ir_id, pc_id} !== {1'b0, 1'b0, 32'h0, 32'h0}) begin
        fails++;
        $display("FAIL mid_rst_n%0d: got req=%b v=%b ir=%h pc=%h, want 0 0 0 0", i, imem_req, valid_id, ir_id, pc_id);
      end
    end
    rst = 1'b0;
    #1;
    tests++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
      fails++;
      $display("FAIL mid_restart_req: got req=%b addr=%h, want 1 00000000", imem_req, imem_addr);
    end
    repeat (4) @(negedge clk);
    tests++;
    if ({valid_id, ir_id, pc_id} !== {1'b1, 32'h0, 32'h4}) begin
      fails++;
      $display("FAIL mid_restart_data: got v=%b ir=%h pc=%h, want 1 0 4", valid_id, ir_id, pc_id);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_gnt_hold();
    test_latency3();
    test_redirect_discard();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
